// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: rebuilds a 4-digit value from active-low multiplexed FND
// scan lines and publishes binary/BCD/DP once per complete scan frame.
module fnd_scan_decoder #(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] number,
  output logic [15:0] bcd,
  output logic [3:0]  dp,
  output logic        valid,
  output logic        frame_err,
  output logic        stale
);

  localparam int SCW = $clog2(STABLE_CYC);
  localparam int TCW = $clog2(TIMEOUT_CYC);
  localparam logic [SCW-1:0] STB_TOP = SCW'(STABLE_CYC - 1);
  localparam logic [TCW-1:0] TO_TOP  = TCW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

  function automatic logic [3:0] seg_to_digit(input logic [6:0] s);
    logic [3:0] d;
    case (s)
      7'h40:   d = 4'd0;
      7'h79:   d = 4'd1;
      7'h24:   d = 4'd2;
      7'h30:   d = 4'd3;
      7'h19:   d = 4'd4;
      7'h12:   d = 4'd5;
      7'h02:   d = 4'd6;
      7'h78:   d = 4'd7;
      7'h00:   d = 4'd8;
      7'h10:   d = 4'd9;
      default: d = 4'hF;
    endcase
    return d;
  endfunction

  logic [11:0]      r_in;
  logic [SCW-1:0]   r_cnt;
  logic             r_done;
  state_t           r_state;
  logic [3:0]       r_mask;
  logic             r_err;
  logic [TCW-1:0]   r_to_cnt;
  logic [3:0][3:0]  r_dig;
  logic [3:0]       r_dpc;
  logic [15:0]      r_number;
  logic [15:0]      r_bcd;
  logic [3:0]       r_dp;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_stale;

  logic             w_change;
  logic             w_top;
  logic             w_one_low;
  logic [1:0]       w_slot;
  logic [3:0]       w_digit;
  logic             w_cap;
  logic             w_timeout;
  logic [3:0]       w_mask_nxt;
  logic [15:0]      w_sum;

  assign w_change   = ({an, seg} != r_in);
  assign w_top      = (r_cnt == STB_TOP);
  assign w_digit    = seg_to_digit(r_in[6:0]);
  assign w_cap      = w_top && !r_done && w_one_low;
  assign w_timeout  = (r_mask != 4'd0) && (r_to_cnt == TO_TOP);
  assign w_mask_nxt = r_mask | ~r_in[11:8];
  assign w_sum      = ({12'd0, r_dig[3]} * 16'd1000) + ({12'd0, r_dig[2]} * 16'd100)
                    + ({12'd0, r_dig[1]} * 16'd10) + {12'd0, r_dig[0]};

  // Only a single lit common identifies a digit slot; blanking or ghosting does not.
  always_comb begin
    w_one_low = 1'b0;
    w_slot    = 2'd0;
    case (r_in[11:8])
      4'b1110: begin w_one_low = 1'b1; w_slot = 2'd0; end
      4'b1101: begin w_one_low = 1'b1; w_slot = 2'd1; end
      4'b1011: begin w_one_low = 1'b1; w_slot = 2'd2; end
      4'b0111: begin w_one_low = 1'b1; w_slot = 2'd3; end
      default: begin w_one_low = 1'b0; w_slot = 2'd0; end
    endcase
  end

  // r_done marks the stable window as consumed so it yields at most one capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in   <= 12'hFFF;
      r_cnt  <= {SCW{1'b0}};
      r_done <= 1'b0;
    end else if (w_change) begin
      r_in   <= {an, seg};
      r_cnt  <= {SCW{1'b0}};
      r_done <= 1'b0;
    end else begin
      r_in   <= r_in;
      r_cnt  <= w_top ? r_cnt : (r_cnt + SCW'(1));
      r_done <= r_done | w_top;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_COLLECT;
      r_mask      <= 4'd0;
      r_err       <= 1'b0;
      r_to_cnt    <= {TCW{1'b0}};
      r_dig       <= 16'd0;
      r_dpc       <= 4'd0;
      r_number    <= 16'd0;
      r_bcd       <= 16'd0;
      r_dp        <= 4'd0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_stale     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_stale <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          // Timeout takes priority over a coincident capture.
          if (w_timeout) begin
            r_stale  <= 1'b1;
            r_mask   <= 4'd0;
            r_err    <= 1'b0;
            r_to_cnt <= {TCW{1'b0}};
          end else if (w_cap) begin
            r_dig[w_slot] <= w_digit;
            r_dpc[w_slot] <= ~r_in[7];
            r_mask        <= w_mask_nxt;
            r_err         <= r_err | (w_digit == 4'hF);
            r_to_cnt      <= {TCW{1'b0}};
            if (w_mask_nxt == 4'b1111) begin
              r_state <= ST_CONVERT;
            end else begin
              r_state <= ST_COLLECT;
            end
          end else if (r_mask != 4'd0) begin
            r_to_cnt <= r_to_cnt + TCW'(1);
          end else begin
            r_to_cnt <= r_to_cnt;
          end
        end
        ST_CONVERT: begin
          r_valid     <= 1'b1;
          r_bcd       <= r_dig;
          r_dp        <= r_dpc;
          r_frame_err <= r_err;
          if (!r_err) begin
            r_number <= w_sum;
          end else begin
            r_number <= r_number;
          end
          r_state <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          r_mask   <= 4'd0;
          r_err    <= 1'b0;
          r_to_cnt <= {TCW{1'b0}};
          r_state  <= ST_COLLECT;
        end
        default: begin
          r_state <= ST_COLLECT;
        end
      endcase
    end
  end

  assign number    = r_number;
  assign bcd       = r_bcd;
  assign dp        = r_dp;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign stale     = r_stale;

endmodule
